normlzcseq: RTL

Iterative leading-zero scanner and shift-amount generator that sits directly upstream of the normalization shifter. It accepts an unnormalized significand, scans it MSB-first CHUNK bits per cycle, and hands the registered significand plus a ready-to-use left-shift amount to the shifter stage over a valid/ready handshake. It is the area-reduced alternative to a single-cycle full-width LZC on the int→fp and subnormal-input normalization paths.

---
 rtl/normlzcseq.sv | 118 +++++++++++
 1 files changed

// File: rtl/normlzcseq.sv
// Iterative MSB-first leading-zero scanner feeding the normalization shifter.
// It examines CHUNK bits per cycle and presents the significand with a clamped left-shift amount.
module normlzcseq #(
  parameter int NORMSHIFTSZ    = 64,
  parameter int CHUNK          = 8,
  parameter int LOGNORMSHIFTSZ = $clog2(NORMSHIFTSZ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      Flush,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic [NORMSHIFTSZ-1:0]    InData,
  input  logic                      DropLead,
  output logic                      OutValid,
  input  logic                      OutReady,
  output logic [NORMSHIFTSZ-1:0]    OutShiftIn,
  output logic [LOGNORMSHIFTSZ-1:0] OutShiftAmt,
  output logic                      OutZero,
  output logic                      OutSat
);
  localparam int NCHUNK = NORMSHIFTSZ / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int CLZW   = $clog2(CHUNK);
  localparam int SUMW   = LOGNORMSHIFTSZ + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t r_state, w_next;

  logic [IDXW-1:0]           r_idx;
  logic [NORMSHIFTSZ-1:0]    r_data, r_shin;
  logic                      r_drop, r_zero, r_sat;
  logic [LOGNORMSHIFTSZ-1:0] r_amt;

  logic                      w_accept, w_last, w_hit, w_sat;
  logic [NORMSHIFTSZ-1:0]    w_shifted;
  logic [CHUNK-1:0]          w_chunk;
  logic [CLZW-1:0]           w_clz;
  logic [SUMW-1:0]           w_sum;
  logic [LOGNORMSHIFTSZ-1:0] w_amt;

  assign InReady  = (r_state == IDLE) | ((r_state == DONE) & OutReady);
  assign w_accept = InValid & InReady & ~Flush;

  // Shifting the working copy left lines up the current chunk at the MSB end.
  assign w_shifted = r_data << (r_idx * CHUNK);
  assign w_chunk   = w_shifted[NORMSHIFTSZ-1 -: CHUNK];
  assign w_hit     = |w_chunk;
  assign w_last    = (r_idx == IDXW'(NCHUNK - 1));

  // Ascending loop: the highest set bit is the last to assign.
  always_comb begin
    w_clz = '0;
    for (int i = 0; i < CHUNK; i++)
      if (w_chunk[i]) w_clz = CLZW'(CHUNK - 1 - i);
  end

  assign w_sum = SUMW'(r_idx) * SUMW'(CHUNK) + SUMW'(w_clz) + SUMW'(r_drop);
  assign w_sat = (w_sum > SUMW'(NORMSHIFTSZ - 1));
  assign w_amt = w_sat ? LOGNORMSHIFTSZ'(NORMSHIFTSZ - 1) : w_sum[LOGNORMSHIFTSZ-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (Flush) w_next = IDLE;
    else begin
      case (r_state)
        IDLE:    if (w_accept) w_next = SCAN;
        SCAN:    if (w_hit || w_last) w_next = DONE;
        DONE:    if (OutReady) w_next = w_accept ? SCAN : IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  // Output registers load only when a scan completes, so they stay put while waiting on OutReady.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_idx  <= '0;
      r_data <= '0;
      r_drop <= 1'b0;
      r_shin <= '0;
      r_amt  <= '0;
      r_zero <= 1'b0;
      r_sat  <= 1'b0;
    end else if (!Flush) begin
      if (w_accept) begin
        r_data <= InData;
        r_drop <= DropLead;
        r_idx  <= '0;
      end else if (r_state == SCAN) begin
        if (w_hit) begin
          r_shin <= r_data;
          r_amt  <= w_amt;
          r_zero <= 1'b0;
          r_sat  <= w_sat;
        end else if (w_last) begin
          r_shin <= r_data;
          r_amt  <= '0;
          r_zero <= 1'b1;
          r_sat  <= 1'b0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign OutValid    = (r_state == DONE);
  assign OutShiftIn  = r_shin;
  assign OutShiftAmt = r_amt;
  assign OutZero     = r_zero;
  assign OutSat      = r_sat;
endmodule
